fc_link_ctrl: RTL
=================

Name: fc_link_ctrl

Overview:
FC-FS port-state controller sitting between the 8G transceiver's parallel interface and the frame datapath. Recognises received primitive sequences and sequences link initialisation (OLS/LR/LRR/Idle handshake). Selects each cycle whether the transmit word is a primitive or a user frame beat. Gates received data to the frame path only in ACTIVE.

Parameters:
SYNC_LOSS_CYC, 255, consecutive cycles of rx_sync low before entering LF2.
TIMEOUT_CYC, 2**20, cycles without a state change in LR1/LR2/LR3/OL1/OL2/LF1 before forcing LF2.
SEQ_CNT, 3, consecutive identical ordered sets needed to recognise a sequence.

Ports:
clk  in  1  single clock; all logic, including the transceiver side, is synchronous to it.
reset  in  1  synchronous, active-high.
rx_word  in  32  received parallel word; byte 0 (bits 7:0) arrives first.
rx_wordk  in  4  per-byte K flag.
rx_sync  in  1  AND of the transceiver syncstatus bits and rx ready.
xcvr_tx_ready  in  1  transceiver TX ready.
tx_word  out  32  word to the transceiver.
tx_wordk  out  4  per-byte K flag.
usr_tx_data/valid/sop/eop  in  32/1/1/1  frame stream in.
usr_tx_ready  out  1  frame stream backpressure.
usr_rx_valid  out  1  high when rx_word is frame-path valid.
lr_req  in  1  single-cycle pulse: start a link reset.
ols_req  in  1  single-cycle pulse: go offline.
link_state  out  4  current link_state_t.
link_up  out  1  high in ACTIVE.
frame_abort  out  1  single-cycle pulse on a truncated frame.
prim_cnt  out  128  four 32-bit counters: {LRR, LR, OLS, NOS}.

Behaviour:
- Ordered-set constants (bits 31:0, wordk 4'b0001):
  - IDLE 32'hB5B595BC
  - NOS 32'h45BF55BC
  - OLS 32'h558A35BC
  - LR 32'h49BF49BC
  - LRR 32'h49BF35BC
- Sequence recogniser:
  - Registers the previous word and keeps a match counter that saturates at SEQ_CNT.
  - The counter resets to 1 when the word changes, and resets to 0 when the word is not a known ordered set or rx_sync=0.
  - rx_seq is asserted on the cycle the counter reaches SEQ_CNT. Decode latency is SEQ_CNT cycles; the state changes on the following cycle.
- States (link_state_t): ACTIVE=0, LR1, LR2, LR3, LF1, LF2, OL1, OL2. Reset state is OL1.
- Transmit word per state:
  - OL1, LF1: OLS.
  - OL2, LR1: LR.
  - LR2: LRR.
  - LR3, ACTIVE: IDLE.
  - LF2: NOS.
- Transition priority, highest first:
  1. Sync loss: rx_sync low for SYNC_LOSS_CYC consecutive cycles → LF2.
  2. Timeout: TIMEOUT_CYC expires → LF2.
  3. ols_req → OL1.
  4. lr_req → LR1, honoured only from ACTIVE.
  5. Received sequence, per state:
     - ACTIVE: LR → LR2; OLS → OL2; NOS → LF1; LRR → LR3.
     - LR1: LR → LR2; LRR → LR3.
     - LR2: LRR → LR3; IDLE → ACTIVE.
     - LR3: IDLE → ACTIVE; LR → LR2.
     - OL1, LF1, LF2: OLS → OL2; LR → LR2; NOS → LF1. In LF1, NOS is ignored.
     - OL2: LR → LR2; LRR → LR3; NOS → LF1.
- The timeout counter clears on every state change.
- tx_word/tx_wordk are registered (1-cycle latency).
  - In ACTIVE, a beat is transmitted when usr_tx_valid && usr_tx_ready; otherwise IDLE.
  - usr_tx_ready = (state==ACTIVE) && xcvr_tx_ready, or drain mode.
- Leaving ACTIVE mid-frame (after sop, before eop):
  - Primitives start the next cycle.
  - Drain mode holds usr_tx_ready=1 and discards beats through eop.
  - frame_abort pulses when the drain completes.
  - sop and eop on the same beat is a complete frame.
- usr_rx_valid = (state==ACTIVE) && rx_sync && rx_wordk==0.
- Values after reset:
  - tx_word = OLS, tx_wordk = 4'b0001.
  - usr_tx_ready = 0, usr_rx_valid = 0, link_up = 0, frame_abort = 0.
  - Counters, drain flag and match counter are 0.
- A reset asserted mid-operation returns to these values on the next clk edge, with no drain.

Optional Feature:
FC_LINK_CTRL_PRIM_CNT_EN:
- Defined: prim_cnt holds 32-bit saturating counts of recognised NOS/OLS/LR/LRR sequences. Each counter increments once per rx_seq assertion and clears on reset.
- Undefined: prim_cnt is tied to 0 and the counters are not synthesised.

Decomposition:
- Package fc_link_pkg:
  - link_state_t.
  - Ordered-set constants FC_OS_IDLE/NOS/OLS/LR/LRR.
  - seq_t enum: SEQ_NONE, SEQ_IDLE, SEQ_NOS, SEQ_OLS, SEQ_LR, SEQ_LRR.
- Sub-module fc_seq_detect: recogniser; outputs seq_t and a strobe.

Test Plan:
- Reset, then feed 3×OLS, then 3×LRR, then 3×IDLE.
  → OL1 → OL2 (tx 32'h49BF49BC) → LR3 → ACTIVE; link_up=1.
- In ACTIVE, send a 4-beat frame with xcvr_tx_ready=1.
  → tx_word equals the beats 1 cycle later, then IDLE 32'hB5B595BC.
- Mid-frame, 3×LR received.
  → LR2 with tx LRR; remaining beats accepted and discarded; frame_abort pulses at eop.
- rx_sync low for 254 cycles → no change; low for 255 cycles → LF2 with tx 32'h45BF55BC.
- Alternating OLS/NOS words → no transition. Two OLS, then a K-error word, then three OLS → OL2 only after the final three.
- Hold OL2 with no response → LF2 after exactly TIMEOUT_CYC. With FC_LINK_CTRL_PRIM_CNT_EN defined, 5 LR sequences → prim_cnt[95:64]=5.

Source files
------------

// File: rtl/fc_link_ctrl_pkg.sv
// Shared types, ordered-set constants and decode helpers for the FC link controller.
package fc_link_pkg;

  typedef enum logic [3:0] {
    ST_ACTIVE = 4'd0,
    ST_LR1    = 4'd1,
    ST_LR2    = 4'd2,
    ST_LR3    = 4'd3,
    ST_LF1    = 4'd4,
    ST_LF2    = 4'd5,
    ST_OL1    = 4'd6,
    ST_OL2    = 4'd7
  } link_state_t;

  typedef enum logic [2:0] {
    SEQ_NONE = 3'd0,
    SEQ_IDLE = 3'd1,
    SEQ_NOS  = 3'd2,
    SEQ_OLS  = 3'd3,
    SEQ_LR   = 3'd4,
    SEQ_LRR  = 3'd5
  } seq_t;

  localparam logic [31:0] FC_OS_IDLE = 32'hB5B595BC;
  localparam logic [31:0] FC_OS_NOS  = 32'h45BF55BC;
  localparam logic [31:0] FC_OS_OLS  = 32'h558A35BC;
  localparam logic [31:0] FC_OS_LR   = 32'h49BF49BC;
  localparam logic [31:0] FC_OS_LRR  = 32'h49BF35BC;
  localparam logic [3:0]  FC_OS_K    = 4'b0001;

  function automatic seq_t os_decode(input logic [31:0] word, input logic [3:0] wordk);
    seq_t s;
    s = SEQ_NONE;
    if (wordk == FC_OS_K) begin
      case (word)
        FC_OS_IDLE: s = SEQ_IDLE;
        FC_OS_NOS:  s = SEQ_NOS;
        FC_OS_OLS:  s = SEQ_OLS;
        FC_OS_LR:   s = SEQ_LR;
        FC_OS_LRR:  s = SEQ_LRR;
        default:    s = SEQ_NONE;
      endcase
    end else begin
      s = SEQ_NONE;
    end
    return s;
  endfunction

  function automatic logic [31:0] os_word(input link_state_t st);
    case (st)
      ST_OL1, ST_LF1: return FC_OS_OLS;
      ST_OL2, ST_LR1: return FC_OS_LR;
      ST_LR2:         return FC_OS_LRR;
      ST_LF2:         return FC_OS_NOS;
      default:        return FC_OS_IDLE;
    endcase
  endfunction

  function automatic logic is_timed(input link_state_t st);
    case (st)
      ST_LR1, ST_LR2, ST_LR3, ST_OL1, ST_OL2, ST_LF1: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  // Reaction to a recognised sequence; anything unlisted leaves the state unchanged.
  function automatic link_state_t seq_next(input link_state_t st, input seq_t seq);
    link_state_t n;
    n = st;
    case (st)
      ST_ACTIVE: case (seq)
        SEQ_LR:  n = ST_LR2;
        SEQ_OLS: n = ST_OL2;
        SEQ_NOS: n = ST_LF1;
        SEQ_LRR: n = ST_LR3;
        default: n = st;
      endcase
      ST_LR1: case (seq)
        SEQ_LR:  n = ST_LR2;
        SEQ_LRR: n = ST_LR3;
        default: n = st;
      endcase
      ST_LR2: case (seq)
        SEQ_LRR:  n = ST_LR3;
        SEQ_IDLE: n = ST_ACTIVE;
        default:  n = st;
      endcase
      ST_LR3: case (seq)
        SEQ_IDLE: n = ST_ACTIVE;
        SEQ_LR:   n = ST_LR2;
        default:  n = st;
      endcase
      ST_OL1, ST_LF1, ST_LF2: case (seq)
        SEQ_OLS: n = ST_OL2;
        SEQ_LR:  n = ST_LR2;
        SEQ_NOS: n = ST_LF1;
        default: n = st;
      endcase
      ST_OL2: case (seq)
        SEQ_LR:  n = ST_LR2;
        SEQ_LRR: n = ST_LR3;
        SEQ_NOS: n = ST_LF1;
        default: n = st;
      endcase
      default: n = st;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fc_link_ctrl_if.sv
// User transmit frame stream between the frame datapath and the link controller.
interface fc_link_ctrl_if;
  logic [31:0] usr_tx_data;
  logic        usr_tx_valid;
  logic        usr_tx_sop;
  logic        usr_tx_eop;
  logic        usr_tx_ready;

  modport master (output usr_tx_data, usr_tx_valid, usr_tx_sop, usr_tx_eop, input usr_tx_ready);
  modport slave  (input usr_tx_data, usr_tx_valid, usr_tx_sop, usr_tx_eop, output usr_tx_ready);
endinterface

// File: rtl/fc_link_ctrl_seq_detect.sv
// Primitive-sequence recogniser: strobes once when SEQ_CNT identical ordered sets
// have arrived back to back with rx_sync held high.
module fc_seq_detect
  import fc_link_pkg::*;
#(
  parameter int SEQ_CNT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rx_word,
  input  logic [3:0]  rx_wordk,
  input  logic        rx_sync,
  output seq_t        seq,
  output logic        seq_vld
);

  localparam int CW = $clog2(SEQ_CNT + 1);

  seq_t          cur_s;
  seq_t          prev_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          vld_s;
  logic          vld_r;

  // Match counter update and first-reach detection
  always_comb begin
    cur_s      = os_decode(rx_word, rx_wordk);
    cnt_next_s = cnt_r;
    if (!rx_sync || (cur_s == SEQ_NONE)) begin
      cnt_next_s = '0;
    end else if ((cur_s != prev_r) || (cnt_r == '0)) begin
      cnt_next_s = CW'(1);
    end else if (cnt_r != CW'(SEQ_CNT)) begin
      cnt_next_s = cnt_r + CW'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
    vld_s = (cnt_next_s == CW'(SEQ_CNT)) && ((cnt_r != CW'(SEQ_CNT)) || (cur_s != prev_r));
  end

  // Recogniser state
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= '0;
      prev_r <= SEQ_NONE;
      vld_r  <= 1'b0;
    end else begin
      cnt_r  <= cnt_next_s;
      prev_r <= cur_s;
      vld_r  <= vld_s;
    end
  end

  assign seq     = prev_r;
  assign seq_vld = vld_r;

endmodule

// File: rtl/fc_link_ctrl.sv
// FC port-state controller: link init sequencing, tx word mux, rx frame gating.
// Optional per-primitive sequence counters are built when FC_LINK_CTRL_PRIM_CNT_EN is defined.
module fc_link_ctrl
  import fc_link_pkg::*;
#(
  parameter int SYNC_LOSS_CYC = 255,
  parameter int TIMEOUT_CYC   = 2**20,
  parameter int SEQ_CNT       = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   rx_word,
  input  logic [3:0]    rx_wordk,
  input  logic          rx_sync,
  input  logic          xcvr_tx_ready,
  output logic [31:0]   tx_word,
  output logic [3:0]    tx_wordk,
  fc_link_ctrl_if.slave usr_tx,
  output logic          usr_rx_valid,
  input  logic          lr_req,
  input  logic          ols_req,
  output logic [3:0]    link_state,
  output logic          link_up,
  output logic          frame_abort,
  output logic [127:0]  prim_cnt
);

  localparam int LOS_W = $clog2(SYNC_LOSS_CYC + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  link_state_t      state_r, state_next_s;
  seq_t             rx_seq_s;
  logic             rx_seq_vld_s;
  logic [LOS_W-1:0] los_cnt_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             sync_loss_s, timeout_s;
  logic             usr_ready_s, hs_s, act_hs_s, open_s, leave_s;
  logic             in_frame_r, in_frame_next_s, drain_r, drain_next_s;
  logic             frame_abort_r, link_up_r;
  logic [31:0]      tx_word_r;
  logic [3:0]       tx_wordk_r;

  fc_seq_detect #(.SEQ_CNT(SEQ_CNT)) u_seq_detect (
    .clk      (clk),
    .reset    (reset),
    .rx_word  (rx_word),
    .rx_wordk (rx_wordk),
    .rx_sync  (rx_sync),
    .seq      (rx_seq_s),
    .seq_vld  (rx_seq_vld_s)
  );

  assign sync_loss_s = !rx_sync && (los_cnt_r == LOS_W'(SYNC_LOSS_CYC - 1));
  assign timeout_s   = is_timed(state_r) && (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));
  assign usr_ready_s = ((state_r == ST_ACTIVE) && xcvr_tx_ready) || drain_r;
  assign hs_s        = usr_tx.usr_tx_valid && usr_ready_s;
  assign act_hs_s    = hs_s && (state_r == ST_ACTIVE) && !drain_r;

  // Next-state selection in priority order
  always_comb begin
    state_next_s = state_r;
    if (sync_loss_s) begin
      state_next_s = ST_LF2;
    end else if (timeout_s) begin
      state_next_s = ST_LF2;
    end else if (ols_req) begin
      state_next_s = ST_OL1;
    end else if (lr_req && (state_r == ST_ACTIVE)) begin
      state_next_s = ST_LR1;
    end else if (rx_seq_vld_s) begin
      state_next_s = seq_next(state_r, rx_seq_s);
    end else begin
      state_next_s = state_r;
    end
  end

  // Frame tracking; an open frame at the ACTIVE exit is drained to its eop
  always_comb begin
    open_s          = in_frame_r;
    leave_s         = (state_r == ST_ACTIVE) && (state_next_s != ST_ACTIVE);
    drain_next_s    = drain_r;
    in_frame_next_s = in_frame_r;
    if (act_hs_s && usr_tx.usr_tx_eop) begin
      open_s = 1'b0;
    end else if (act_hs_s && usr_tx.usr_tx_sop) begin
      open_s = 1'b1;
    end else begin
      open_s = in_frame_r;
    end
    if (drain_r) begin
      drain_next_s    = !(hs_s && usr_tx.usr_tx_eop);
      in_frame_next_s = 1'b0;
    end else if (leave_s && open_s) begin
      drain_next_s    = 1'b1;
      in_frame_next_s = 1'b0;
    end else begin
      drain_next_s    = 1'b0;
      in_frame_next_s = open_s;
    end
  end

  // State, watchdog counters, frame flags and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_OL1;
      los_cnt_r     <= '0;
      tmo_cnt_r     <= '0;
      in_frame_r    <= 1'b0;
      drain_r       <= 1'b0;
      frame_abort_r <= 1'b0;
      link_up_r     <= 1'b0;
      tx_word_r     <= FC_OS_OLS;
      tx_wordk_r    <= FC_OS_K;
    end else begin
      state_r       <= state_next_s;
      in_frame_r    <= in_frame_next_s;
      drain_r       <= drain_next_s;
      frame_abort_r <= drain_r && hs_s && usr_tx.usr_tx_eop;
      link_up_r     <= (state_next_s == ST_ACTIVE);
      if (rx_sync) begin
        los_cnt_r <= '0;
      end else if (los_cnt_r != LOS_W'(SYNC_LOSS_CYC - 1)) begin
        los_cnt_r <= los_cnt_r + LOS_W'(1);
      end else begin
        los_cnt_r <= los_cnt_r;
      end
      if ((state_next_s != state_r) || !is_timed(state_r)) begin
        tmo_cnt_r <= '0;
      end else begin
        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end
      if (act_hs_s) begin
        tx_word_r  <= usr_tx.usr_tx_data;
        tx_wordk_r <= 4'b0000;
      end else begin
        tx_word_r  <= os_word(state_r);
        tx_wordk_r <= FC_OS_K;
      end
    end
  end

`ifdef FC_LINK_CTRL_PRIM_CNT_EN
  logic [31:0] cnt_nos_r, cnt_ols_r, cnt_lr_r, cnt_lrr_r;

  // Saturating per-primitive sequence counters
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_nos_r <= 32'd0;
      cnt_ols_r <= 32'd0;
      cnt_lr_r  <= 32'd0;
      cnt_lrr_r <= 32'd0;
    end else if (rx_seq_vld_s) begin
      case (rx_seq_s)
        SEQ_NOS: cnt_nos_r <= sat_inc32(cnt_nos_r);
        SEQ_OLS: cnt_ols_r <= sat_inc32(cnt_ols_r);
        SEQ_LR:  cnt_lr_r  <= sat_inc32(cnt_lr_r);
        SEQ_LRR: cnt_lrr_r <= sat_inc32(cnt_lrr_r);
        default: cnt_nos_r <= cnt_nos_r;
      endcase
    end else begin
      cnt_nos_r <= cnt_nos_r;
    end
  end

  assign prim_cnt = {cnt_lrr_r, cnt_lr_r, cnt_ols_r, cnt_nos_r};
`else
  assign prim_cnt = 128'd0;
`endif

  assign usr_tx.usr_tx_ready = usr_ready_s;
  assign usr_rx_valid        = (state_r == ST_ACTIVE) && rx_sync && (rx_wordk == 4'b0000);
  assign tx_word             = tx_word_r;
  assign tx_wordk            = tx_wordk_r;
  assign link_state          = state_r;
  assign link_up             = link_up_r;
  assign frame_abort         = frame_abort_r;

endmodule
